// File: rtl/frame_manager_pkg.sv
// Shared frame-manager definitions: framebuffer geometry, bus widths, draw
// source IDs and the pixel payload carried on the draw-source write bus.
package frame_manager_pkg;

  localparam int unsigned SOURCE_SEL_ADDRW  = 2;
  localparam int unsigned COLOR_DEPTH       = 12;
  localparam int unsigned DRAW_WIDTH        = 640;
  localparam int unsigned DRAW_HEIGHT       = 480;
  localparam int unsigned DRAW_WIDTH_ADDRW  = 10;
  localparam int unsigned DRAW_HEIGHT_ADDRW = 9;

  // One extra bit so a limit equal to 2**ADDRW still compares correctly.
  localparam logic [DRAW_WIDTH_ADDRW:0]  DRAW_X_LIMIT = (DRAW_WIDTH_ADDRW+1)'(DRAW_WIDTH);
  localparam logic [DRAW_HEIGHT_ADDRW:0] DRAW_Y_LIMIT = (DRAW_HEIGHT_ADDRW+1)'(DRAW_HEIGHT);

  // Draw units in compositing order (back to front).
  typedef enum logic [SOURCE_SEL_ADDRW-1:0] {
    SRC_STARFIELD = 2'd0,
    SRC_SPRITES   = 2'd1,
    SRC_HUD       = 2'd2
  } source_id_e;

  typedef struct packed {
    logic [COLOR_DEPTH-1:0]       color;
    logic                         transparent;
    logic [DRAW_WIDTH_ADDRW-1:0]  x;
    logic [DRAW_HEIGHT_ADDRW-1:0] y;
  } draw_pixel_t;

  // A pixel reaches the framebuffer only if opaque and on screen.
  function automatic logic pixel_writable(draw_pixel_t p);
    return !p.transparent
        && ({1'b0, p.x} < DRAW_X_LIMIT)
        && ({1'b0, p.y} < DRAW_Y_LIMIT);
  endfunction

endpackage

// File: rtl/draw_write_arbiter_if.sv
// Draw-source write bus. The arbiter selects a source and signals readiness;
// the selected source drives its pixel burst.
//   master : draw source side (drives write_active and pixel fields)
//   slave  : arbiter side (drives write_source_sel, write_awaited)
interface draw_write_arbiter_if
  import frame_manager_pkg::*;
();
  logic [SOURCE_SEL_ADDRW-1:0]  write_source_sel;
  logic                         write_awaited;
  logic                         write_active;
  logic [COLOR_DEPTH-1:0]       write_color_data;
  logic                         write_transparent;
  logic [DRAW_WIDTH_ADDRW-1:0]  write_x_addr;
  logic [DRAW_HEIGHT_ADDRW-1:0] write_y_addr;

  modport master (
    input  write_source_sel, write_awaited,
    output write_active, write_color_data, write_transparent,
    output write_x_addr, write_y_addr
  );

  modport slave (
    output write_source_sel, write_awaited,
    input  write_active, write_color_data, write_transparent,
    input  write_x_addr, write_y_addr
  );
endinterface

// File: rtl/draw_pixel_filter.sv
// Framebuffer write stage: drops transparent / off-screen pixels and registers
// the write, one cycle after acceptance.
//   clk, rst    : clock, synchronous active-high reset
//   accept_i    : pixel on pix_i is accepted this cycle
//   pix_i       : pixel payload
//   fb_*_o      : registered framebuffer write port
module draw_pixel_filter
  import frame_manager_pkg::*;
(
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         accept_i,
  input  draw_pixel_t                  pix_i,
  output logic                         fb_we_o,
  output logic [DRAW_WIDTH_ADDRW-1:0]  fb_x_o,
  output logic [DRAW_HEIGHT_ADDRW-1:0] fb_y_o,
  output logic [COLOR_DEPTH-1:0]       fb_color_o
);

  logic                         fb_we_q;
  logic [DRAW_WIDTH_ADDRW-1:0]  fb_x_q;
  logic [DRAW_HEIGHT_ADDRW-1:0] fb_y_q;
  logic [COLOR_DEPTH-1:0]       fb_color_q;

  // Address/colour follow every accepted pixel; only fb_we is qualified.
  always_ff @(posedge clk) begin
    if (rst) begin
      fb_we_q    <= 1'b0;
      fb_x_q     <= '0;
      fb_y_q     <= '0;
      fb_color_q <= '0;
    end else begin
      fb_we_q <= accept_i && pixel_writable(pix_i);
      if (accept_i) begin
        fb_x_q     <= pix_i.x;
        fb_y_q     <= pix_i.y;
        fb_color_q <= pix_i.color;
      end
    end
  end

  assign fb_we_o    = fb_we_q;
  assign fb_x_o     = fb_x_q;
  assign fb_y_o     = fb_y_q;
  assign fb_color_o = fb_color_q;

endmodule

// File: rtl/draw_write_arbiter.sv
// Receiving end of the draw-source write bus. Once per frame, polls every draw
// source in ID order, accepts its pixel burst and forwards writable pixels to
// the back-buffer write port.
//   clk, rst          : clock, synchronous active-high reset
//   frame_start       : pulse, begin compositing a frame
//   wr                : draw-source write bus (slave side)
//   fb_we/x/y/color   : framebuffer write port, 1 cycle after acceptance
//   busy              : frame in progress
//   frame_draw_done   : pulse, last source finished
//   source_timeout    : pulse, source skipped (no start or burst too long)
//   frame_overrun     : pulse, frame_start while a frame was in progress
module draw_write_arbiter
  import frame_manager_pkg::*;
#(
  parameter int unsigned SOURCE_COUNT  = 3,
  parameter int unsigned PARK_SEL      = SOURCE_COUNT,
  parameter int unsigned START_TIMEOUT = 4096,
  parameter int unsigned MAX_BURST     = 65535
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         frame_start,
  draw_write_arbiter_if.slave          wr,
  output logic                         fb_we,
  output logic [DRAW_WIDTH_ADDRW-1:0]  fb_x,
  output logic [DRAW_HEIGHT_ADDRW-1:0] fb_y,
  output logic [COLOR_DEPTH-1:0]       fb_color,
  output logic                         busy,
  output logic                         frame_draw_done,
  output logic                         source_timeout,
  output logic                         frame_overrun
);

  localparam int unsigned TO_W    = $clog2(START_TIMEOUT + 1);
  localparam int unsigned BURST_W = $clog2(MAX_BURST + 1);

  localparam logic [SOURCE_SEL_ADDRW-1:0] PARK      = SOURCE_SEL_ADDRW'(PARK_SEL);
  localparam logic [SOURCE_SEL_ADDRW-1:0] LAST_SRC  = SOURCE_SEL_ADDRW'(SOURCE_COUNT - 1);
  localparam logic [TO_W-1:0]             TO_LAST   = TO_W'(START_TIMEOUT - 1);
  localparam logic [BURST_W-1:0]          BURST_MAX = BURST_W'(MAX_BURST);

  typedef enum logic [2:0] {
    ST_IDLE, ST_SELECT, ST_AWAIT, ST_RECEIVE, ST_NEXT, ST_DONE
  } state_e;

  state_e                      state_q;
  logic [SOURCE_SEL_ADDRW-1:0] src_q;
  logic [SOURCE_SEL_ADDRW-1:0] sel_q;
  logic                        awaited_q;
  logic                        busy_q;
  logic                        done_q;
  logic                        timeout_q;
  logic                        overrun_q;
  logic [TO_W-1:0]             to_cnt_q;
  logic [BURST_W-1:0]          burst_q;
  logic [BURST_W-1:0]          burst_d;
  logic                        act_c;
  logic                        accept_c;
  draw_pixel_t                 pix_c;

  // Floating bus: anything but a clean 1 counts as inactive.
  assign act_c    = (wr.write_active === 1'b1);
  assign accept_c = act_c && ((state_q == ST_AWAIT) || (state_q == ST_RECEIVE));
  assign burst_d  = burst_q + BURST_W'(1);

  always_comb begin
    pix_c             = '0;
    pix_c.color       = wr.write_color_data;
    pix_c.transparent = wr.write_transparent;
    pix_c.x           = wr.write_x_addr;
    pix_c.y           = wr.write_y_addr;
  end

  // Frame sequencer; outputs are updated on the edge entering each state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      src_q     <= '0;
      sel_q     <= PARK;
      awaited_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      timeout_q <= 1'b0;
      overrun_q <= 1'b0;
      to_cnt_q  <= '0;
      burst_q   <= '0;
    end else begin
      done_q    <= 1'b0;
      timeout_q <= 1'b0;
      overrun_q <= frame_start && (state_q != ST_IDLE);
      unique case (state_q)
        ST_IDLE: begin
          if (frame_start) begin
            src_q   <= '0;
            sel_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= ST_SELECT;
          end
        end
        // Settle cycle for the source-side tri-state mux.
        ST_SELECT: begin
          to_cnt_q  <= '0;
          burst_q   <= '0;
          awaited_q <= 1'b1;
          state_q   <= ST_AWAIT;
        end
        ST_AWAIT: begin
          if (act_c) begin
            awaited_q <= 1'b0;
            burst_q   <= burst_d;
            if (burst_d == BURST_MAX) begin
              timeout_q <= 1'b1;
              sel_q     <= PARK;
              state_q   <= ST_NEXT;
            end else begin
              state_q <= ST_RECEIVE;
            end
          end else if (to_cnt_q == TO_LAST) begin
            awaited_q <= 1'b0;
            timeout_q <= 1'b1;
            sel_q     <= PARK;
            state_q   <= ST_NEXT;
          end else begin
            to_cnt_q <= to_cnt_q + TO_W'(1);
          end
        end
        ST_RECEIVE: begin
          if (!act_c) begin
            sel_q   <= PARK;
            state_q <= ST_NEXT;
          end else begin
            burst_q <= burst_d;
            if (burst_d == BURST_MAX) begin
              timeout_q <= 1'b1;
              sel_q     <= PARK;
              state_q   <= ST_NEXT;
            end
          end
        end
        ST_NEXT: begin
          if (src_q == LAST_SRC) begin
            done_q  <= 1'b1;
            state_q <= ST_DONE;
          end else begin
            src_q   <= src_q + SOURCE_SEL_ADDRW'(1);
            sel_q   <= src_q + SOURCE_SEL_ADDRW'(1);
            state_q <= ST_SELECT;
          end
        end
        ST_DONE: begin
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  draw_pixel_filter u_filter (
    .clk        (clk),
    .rst        (rst),
    .accept_i   (accept_c),
    .pix_i      (pix_c),
    .fb_we_o    (fb_we),
    .fb_x_o     (fb_x),
    .fb_y_o     (fb_y),
    .fb_color_o (fb_color)
  );

  assign wr.write_source_sel = sel_q;
  assign wr.write_awaited    = awaited_q;
  assign busy                = busy_q;
  assign frame_draw_done     = done_q;
  assign source_timeout      = timeout_q;
  assign frame_overrun       = overrun_q;

endmodule
